// File: rtl/calc_multiport.sv
// Multi-port calculator: NUM_PORTS requesters, each with a small command FSM,
// sharing one pipelined ALU through a round-robin arbiter.
module calc_multiport #(
    parameter int NUM_PORTS  = 4,
    parameter int DATA_W     = 32,
    parameter int ALU_STAGES = 1
) (
    input  logic                        c_clk,
    input  logic                        reset,
    input  logic [4*NUM_PORTS-1:0]      req_cmd_in,
    input  logic [DATA_W*NUM_PORTS-1:0] req_data_in,
    output logic [2*NUM_PORTS-1:0]      out_resp,
    output logic [DATA_W*NUM_PORTS-1:0] out_data,
    output logic [NUM_PORTS-1:0]        busy
);

    localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int SW = $clog2(DATA_W);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_OP2,
        ST_PEND,
        ST_WAIT
    } state_t;

    state_t            state_q [NUM_PORTS];
    state_t            state_d [NUM_PORTS];
    logic [3:0]        cmd_q   [NUM_PORTS];
    logic [3:0]        cmd_d   [NUM_PORTS];
    logic [DATA_W-1:0] op1_q   [NUM_PORTS];
    logic [DATA_W-1:0] op1_d   [NUM_PORTS];
    logic [DATA_W-1:0] op2_q   [NUM_PORTS];
    logic [DATA_W-1:0] op2_d   [NUM_PORTS];
    logic [1:0]        resp_q  [NUM_PORTS];
    logic [1:0]        resp_d  [NUM_PORTS];
    logic [DATA_W-1:0] rdata_q [NUM_PORTS];
    logic [DATA_W-1:0] rdata_d [NUM_PORTS];

    logic [PW-1:0]     ptr_q;
    logic [PW-1:0]     ptr_d;
    logic              gnt_vld;
    logic [PW-1:0]     gnt_idx;

    logic [3:0]        iss_cmd;
    logic [DATA_W-1:0] iss_a;
    logic [DATA_W-1:0] iss_b;
    logic [DATA_W:0]   iss_sum;
    logic [1:0]        iss_resp;
    logic [DATA_W-1:0] iss_data;

    logic              ret_vld;
    logic [PW-1:0]     ret_port;
    logic [1:0]        ret_resp;
    logic [DATA_W-1:0] ret_data;

    // Round-robin: first pending port at or above the pointer, else the
    // lowest pending port (the wrap-around case).
    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (!gnt_vld && state_q[p] == ST_PEND && PW'(p) >= ptr_q) begin
                gnt_vld = 1'b1;
                gnt_idx = PW'(p);
            end
        end
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (!gnt_vld && state_q[p] == ST_PEND) begin
                gnt_vld = 1'b1;
                gnt_idx = PW'(p);
            end
        end
        ptr_d = ptr_q;
        if (gnt_vld) begin
            ptr_d = (gnt_idx == PW'(NUM_PORTS - 1)) ? '0 : gnt_idx + PW'(1);
        end
    end

    // The result is formed in the issue cycle and then carried down the pipe.
    always_comb begin
        iss_cmd  = cmd_q[gnt_idx];
        iss_a    = op1_q[gnt_idx];
        iss_b    = op2_q[gnt_idx];
        iss_sum  = {1'b0, iss_a} + {1'b0, iss_b};
        iss_resp = 2'd3;
        iss_data = '0;
        case (iss_cmd)
            4'd1: begin
                if (iss_sum[DATA_W]) begin
                    iss_resp = 2'd2;
                end else begin
                    iss_resp = 2'd1;
                    iss_data = iss_sum[DATA_W-1:0];
                end
            end
            4'd2: begin
                if (iss_b > iss_a) begin
                    iss_resp = 2'd2;
                end else begin
                    iss_resp = 2'd1;
                    iss_data = iss_a - iss_b;
                end
            end
            4'd5: begin
                iss_resp = 2'd1;
                iss_data = iss_a << iss_b[SW-1:0];
            end
            4'd6: begin
                iss_resp = 2'd1;
                iss_data = iss_a >> iss_b[SW-1:0];
            end
            default: ;
        endcase
    end

    // The per-port output register is the last ALU stage, so only
    // ALU_STAGES-1 internal registers sit between issue and retire.
    generate
        if (ALU_STAGES == 1) begin : g_no_pipe
            assign ret_vld  = gnt_vld;
            assign ret_port = gnt_idx;
            assign ret_resp = iss_resp;
            assign ret_data = iss_data;
        end else begin : g_pipe
            localparam int NS = ALU_STAGES - 1;
            logic              pv_q [NS];
            logic [PW-1:0]     pp_q [NS];
            logic [1:0]        pr_q [NS];
            logic [DATA_W-1:0] pd_q [NS];

            always_ff @(posedge c_clk) begin
                if (reset) begin
                    for (int k = 0; k < NS; k++) begin
                        pv_q[k] <= 1'b0;
                        pp_q[k] <= '0;
                        pr_q[k] <= '0;
                        pd_q[k] <= '0;
                    end
                end else begin
                    pv_q[0] <= gnt_vld;
                    pp_q[0] <= gnt_idx;
                    pr_q[0] <= iss_resp;
                    pd_q[0] <= iss_data;
                    for (int k = 1; k < NS; k++) begin
                        pv_q[k] <= pv_q[k-1];
                        pp_q[k] <= pp_q[k-1];
                        pr_q[k] <= pr_q[k-1];
                        pd_q[k] <= pd_q[k-1];
                    end
                end
            end

            assign ret_vld  = pv_q[NS-1];
            assign ret_port = pp_q[NS-1];
            assign ret_resp = pr_q[NS-1];
            assign ret_data = pd_q[NS-1];
        end
    endgenerate

    always_comb begin
        logic hit;
        hit = 1'b0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            state_d[p] = state_q[p];
            cmd_d[p]   = cmd_q[p];
            op1_d[p]   = op1_q[p];
            op2_d[p]   = op2_q[p];
            resp_d[p]  = 2'd0;
            rdata_d[p] = '0;
            hit        = ret_vld && (ret_port == PW'(p));
            if (hit) begin
                resp_d[p]  = ret_resp;
                rdata_d[p] = ret_data;
            end
            case (state_q[p])
                ST_IDLE: begin
                    if (req_cmd_in[p*4 +: 4] != 4'd0) begin
                        cmd_d[p]   = req_cmd_in[p*4 +: 4];
                        op1_d[p]   = req_data_in[p*DATA_W +: DATA_W];
                        state_d[p] = ST_OP2;
                    end
                end
                ST_OP2: begin
                    op2_d[p]   = req_data_in[p*DATA_W +: DATA_W];
                    state_d[p] = ST_PEND;
                end
                ST_PEND: begin
                    // With a single ALU stage the grant and the retire coincide.
                    if (gnt_vld && gnt_idx == PW'(p)) begin
                        state_d[p] = hit ? ST_IDLE : ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (hit) begin
                        state_d[p] = ST_IDLE;
                    end
                end
                default: state_d[p] = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge c_clk) begin
        if (reset) begin
            ptr_q <= '0;
            for (int p = 0; p < NUM_PORTS; p++) begin
                state_q[p] <= ST_IDLE;
                cmd_q[p]   <= '0;
                op1_q[p]   <= '0;
                op2_q[p]   <= '0;
                resp_q[p]  <= '0;
                rdata_q[p] <= '0;
            end
        end else begin
            ptr_q <= ptr_d;
            for (int p = 0; p < NUM_PORTS; p++) begin
                state_q[p] <= state_d[p];
                cmd_q[p]   <= cmd_d[p];
                op1_q[p]   <= op1_d[p];
                op2_q[p]   <= op2_d[p];
                resp_q[p]  <= resp_d[p];
                rdata_q[p] <= rdata_d[p];
            end
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_out
            assign out_resp[gi*2 +: 2]           = resp_q[gi];
            assign out_data[gi*DATA_W +: DATA_W] = rdata_q[gi];
            assign busy[gi]                      = (state_q[gi] != ST_IDLE);
        end
    endgenerate

endmodule

// File: tb/tb_calc_multiport.sv
// Directed bench for calc_multiport: a per-port expected-response model checked
// on every cycle, plus literal expectations for results and latencies.
module tb_calc_multiport;

    localparam int NP = 4;
    localparam int DW = 32;
    localparam int AS = 1;

    logic              c_clk = 1'b0;
    logic              reset = 1'b1;
    logic [4*NP-1:0]   req_cmd_in;
    logic [DW*NP-1:0]  req_data_in;
    logic [2*NP-1:0]   out_resp;
    logic [DW*NP-1:0]  out_data;
    logic [NP-1:0]     busy;

    calc_multiport #(
        .NUM_PORTS (NP),
        .DATA_W    (DW),
        .ALU_STAGES(AS)
    ) dut (
        .c_clk      (c_clk),
        .reset      (reset),
        .req_cmd_in (req_cmd_in),
        .req_data_in(req_data_in),
        .out_resp   (out_resp),
        .out_data   (out_data),
        .busy       (busy)
    );

    always #5 c_clk = ~c_clk;

    int cyc = 0;
    always @(posedge c_clk) cyc <= cyc + 1;

    int          n_checks = 0;
    int          n_errors = 0;
    bit          exp_valid [NP];
    logic [1:0]  exp_resp  [NP];
    logic [31:0] exp_data  [NP];
    int          t_issue   [NP];
    int          resp_cyc  [NP];
    int          resp_cnt  [NP];
    logic [1:0]  last_resp [NP];
    logic [31:0] last_data [NP];
    logic [3:0]  stim_cmd  [NP];
    logic [31:0] stim_a    [NP];
    logic [31:0] stim_b    [NP];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // Reference arithmetic: 64-bit sums for carry, shift amount = op2 mod 32.
    function automatic logic [33:0] model(input logic [3:0] c, input logic [31:0] a,
                                          input logic [31:0] b);
        longint sum;
        int     amt;
        amt = int'(b % 32);
        sum = longint'(a) + longint'(b);
        if (c == 4'd0) return {2'd0, 32'd0};
        if (c == 4'd1) begin
            if (sum > 64'h0000_0000_FFFF_FFFF) return {2'd2, 32'd0};
            return {2'd1, sum[31:0]};
        end
        if (c == 4'd2) begin
            if (b > a) return {2'd2, 32'd0};
            return {2'd1, a - b};
        end
        if (c == 4'd5) return {2'd1, a << amt};
        if (c == 4'd6) return {2'd1, a >> amt};
        return {2'd3, 32'd0};
    endfunction

    // Response monitor: every visible response must match the model for that port.
    always @(negedge c_clk) begin
        int          nr;
        logic [1:0]  r;
        logic [31:0] d;
        nr = 0;
        for (int p = 0; p < NP; p++) begin
            r = out_resp[p*2 +: 2];
            d = out_data[p*DW +: DW];
            if (r != 2'd0) begin
                nr++;
                resp_cnt[p]++;
                resp_cyc[p]  = cyc;
                last_resp[p] = r;
                last_data[p] = d;
                chk($sformatf("resp_expected_p%0d", p), 64'(exp_valid[p]), 64'd1);
                chk($sformatf("resp_code_p%0d", p), 64'(r), 64'(exp_resp[p]));
                chk($sformatf("resp_data_p%0d", p), 64'(d), 64'(exp_data[p]));
                chk($sformatf("busy_at_resp_p%0d", p), 64'(busy[p]), 64'd0);
                exp_valid[p] = 1'b0;
            end else begin
                chk($sformatf("idle_data_zero_p%0d", p), 64'(d), 64'd0);
            end
        end
        chk("single_retire", 64'(nr <= 1), 64'd1);
    end

    task automatic fire(input logic [NP-1:0] mask);
        @(posedge c_clk); #1;
        for (int p = 0; p < NP; p++) begin
            if (mask[p]) begin
                req_cmd_in[p*4 +: 4]   = stim_cmd[p];
                req_data_in[p*DW +: DW] = stim_a[p];
                {exp_resp[p], exp_data[p]} = model(stim_cmd[p], stim_a[p], stim_b[p]);
                exp_valid[p] = 1'b1;
                t_issue[p]   = cyc;
                resp_cyc[p]  = -100;
            end
        end
        @(posedge c_clk); #1;
        for (int p = 0; p < NP; p++) begin
            if (mask[p]) begin
                req_cmd_in[p*4 +: 4]   = 4'd0;
                req_data_in[p*DW +: DW] = stim_b[p];
                chk($sformatf("busy_after_cmd_p%0d", p), 64'(busy[p]), 64'd1);
            end
        end
        @(posedge c_clk); #1;
        for (int p = 0; p < NP; p++) begin
            if (mask[p]) req_data_in[p*DW +: DW] = '0;
        end
    endtask

    task automatic wait_idle(input string name);
        bit done;
        bit pend;
        done = 1'b0;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge c_clk);
            pend = 1'b0;
            for (int p = 0; p < NP; p++) pend |= exp_valid[p];
            if (busy == '0 && !pend) done = 1'b1;
        end
        chk({name, "_timeout"}, 64'(done), 64'd1);
    endtask

    task automatic run_one(input int p, input logic [3:0] c, input logic [31:0] a,
                           input logic [31:0] b, input logic [1:0] er,
                           input logic [31:0] ed, input string name);
        logic [NP-1:0] m;
        m = '0;
        m[p] = 1'b1;
        stim_cmd[p] = c;
        stim_a[p]   = a;
        stim_b[p]   = b;
        fire(m);
        wait_idle(name);
        chk({name, "_latency"}, 64'(resp_cyc[p] - t_issue[p]), 64'd3);
        chk({name, "_resp"}, 64'(last_resp[p]), 64'(er));
        chk({name, "_data"}, 64'(last_data[p]), 64'(ed));
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(posedge c_clk);
        #1;
        reset = 1'b0;
        for (int p = 0; p < NP; p++) exp_valid[p] = 1'b0;
    endtask

    initial begin
        int c0;
        int c2;
        req_cmd_in  = '0;
        req_data_in = '0;
        for (int p = 0; p < NP; p++) begin
            exp_valid[p] = 1'b0;
            exp_resp[p]  = '0;
            exp_data[p]  = '0;
            resp_cnt[p]  = 0;
            resp_cyc[p]  = -100;
            t_issue[p]   = 0;
            last_resp[p] = '0;
            last_data[p] = '0;
        end

        // Reset state
        repeat (3) @(posedge c_clk);
        @(negedge c_clk);
        chk("reset_out_resp", 64'(out_resp), 64'd0);
        chk("reset_out_data", 64'(out_data), 64'd0);
        chk("reset_busy", 64'(busy), 64'd0);
        @(posedge c_clk); #1;
        reset = 1'b0;

        // Literal anchors for the model
        chk("model_add_ovf", 64'(model(4'd1, 32'hFFFF_FFFF, 32'd1)), {30'd0, 2'd2, 32'd0});
        chk("model_sub_udf", 64'(model(4'd2, 32'd3, 32'd5)), {30'd0, 2'd2, 32'd0});
        chk("model_shl_mod", 64'(model(4'd5, 32'd1, 32'h25)), {30'd0, 2'd1, 32'h20});
        chk("model_invalid", 64'(model(4'd3, 32'd9, 32'd9)), {30'd0, 2'd3, 32'd0});

        // Walking-bit add on port 0
        for (int k = 0; k < 32; k++) begin
            run_one(0, 4'd1, 32'd1 << k, 32'd0, 2'd1, 32'd1 << k, $sformatf("walk%0d", k));
        end

        // Arithmetic boundaries, shifts, invalid commands
        run_one(0, 4'd1, 32'hFFFF_FFFF, 32'd1, 2'd2, 32'd0, "add_ovf");
        run_one(1, 4'd1, 32'hFFFF_FFFE, 32'd1, 2'd1, 32'hFFFF_FFFF, "add_max");
        run_one(1, 4'd2, 32'd3, 32'd5, 2'd2, 32'd0, "sub_udf");
        run_one(2, 4'd2, 32'd5, 32'd5, 2'd1, 32'd0, "sub_eq");
        run_one(3, 4'd2, 32'd9, 32'd4, 2'd1, 32'd5, "sub_pos");
        run_one(0, 4'd5, 32'h0000_0001, 32'h0000_0025, 2'd1, 32'h0000_0020, "shl5");
        run_one(1, 4'd6, 32'h8000_0000, 32'd31, 2'd1, 32'h0000_0001, "shr31");
        run_one(2, 4'd5, 32'h0000_ABCD, 32'h0000_0040, 2'd1, 32'h0000_ABCD, "shl0");
        run_one(3, 4'd6, 32'h1234_5678, 32'd0, 2'd1, 32'h1234_5678, "shr0");
        run_one(0, 4'd3, 32'd7, 32'd7, 2'd3, 32'd0, "invalid3");
        run_one(3, 4'd15, 32'd7, 32'd7, 2'd3, 32'd0, "invalid15");

        // Commands while busy are ignored: exactly one response on port 2
        c0 = resp_cnt[2];
        @(posedge c_clk); #1;
        req_cmd_in[2*4 +: 4]   = 4'd1;
        req_data_in[2*DW +: DW] = 32'd7;
        {exp_resp[2], exp_data[2]} = model(4'd1, 32'd7, 32'd8);
        exp_valid[2] = 1'b1;
        t_issue[2]   = cyc;
        resp_cyc[2]  = -100;
        @(posedge c_clk); #1;
        req_cmd_in[2*4 +: 4]   = 4'd2;
        req_data_in[2*DW +: DW] = 32'd8;
        chk("ignore_busy", 64'(busy[2]), 64'd1);
        @(posedge c_clk); #1;
        req_cmd_in[2*4 +: 4]   = 4'd6;
        req_data_in[2*DW +: DW] = 32'd1;
        @(posedge c_clk); #1;
        req_cmd_in[2*4 +: 4]   = 4'd0;
        req_data_in[2*DW +: DW] = 32'd0;
        wait_idle("ignore");
        repeat (5) @(negedge c_clk);
        chk("ignore_count", 64'(resp_cnt[2] - c0), 64'd1);
        chk("ignore_data", 64'(last_data[2]), 64'd15);
        chk("ignore_latency", 64'(resp_cyc[2] - t_issue[2]), 64'd3);

        // Contention right after reset: pointer at 0 -> order 0,1,2,3
        do_reset();
        for (int p = 0; p < NP; p++) begin
            stim_cmd[p] = 4'd1;
            stim_a[p]   = 32'(p + 1);
            stim_b[p]   = 32'd100;
        end
        fire(4'hF);
        wait_idle("rr0");
        for (int p = 0; p < NP; p++) begin
            chk($sformatf("rr0_latency_p%0d", p), 64'(resp_cyc[p] - t_issue[p]), 64'(3 + p));
        end

        // A lone grant on port 1 leaves the pointer at 2 -> order 2,3,0,1
        run_one(1, 4'd1, 32'd1, 32'd1, 2'd1, 32'd2, "ptr_setup");
        for (int p = 0; p < NP; p++) begin
            stim_cmd[p] = 4'd1;
            stim_a[p]   = 32'(10 * p);
            stim_b[p]   = 32'd3;
        end
        fire(4'hF);
        wait_idle("rr2");
        for (int p = 0; p < NP; p++) begin
            chk($sformatf("rr2_latency_p%0d", p), 64'(resp_cyc[p] - t_issue[p]),
                64'(3 + ((p + 2) % 4)));
        end

        // Reset with ports 0 and 2 in flight: both requests vanish
        c0 = resp_cnt[0];
        c2 = resp_cnt[2];
        stim_cmd[0] = 4'd1; stim_a[0] = 32'd11; stim_b[0] = 32'd22;
        stim_cmd[2] = 4'd2; stim_a[2] = 32'd50; stim_b[2] = 32'd8;
        fire(4'b0101);
        reset = 1'b1;
        exp_valid[0] = 1'b0;
        exp_valid[2] = 1'b0;
        @(posedge c_clk);
        @(negedge c_clk);
        chk("midrst_resp", 64'(out_resp), 64'd0);
        chk("midrst_data", 64'(out_data), 64'd0);
        chk("midrst_busy", 64'(busy), 64'd0);
        @(posedge c_clk); #1;
        reset = 1'b0;
        repeat (6) @(negedge c_clk);
        chk("midrst_count_p0", 64'(resp_cnt[0] - c0), 64'd0);
        chk("midrst_count_p2", 64'(resp_cnt[2] - c2), 64'd0);
        run_one(0, 4'd1, 32'd40, 32'd2, 2'd1, 32'd42, "post_reset");

        repeat (3) @(posedge c_clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

endmodule
